z80_ram_bridge: RTL
===================

Name: z80_ram_bridge

Overview:
Sits between the Z80 CPU bus and the synchronous single-port RAM block (registered read, 1-cycle latency; ena/rd/wr/addr/din/dout). It decodes CPU memory cycles that hit the RAM's address window and converts each one into exactly one RAM access. It stretches CPU reads with wait_n until the RAM data is valid, then drives the read data back to the CPU. The CPU bus is synchronous to clk, so no synchronisers are needed.

Parameters:
ADDR_W, 14, RAM address width; window size is 2**ADDR_W bytes; legal range 1..16.
BASE_ADDR, 16'h4000, window base; bits [ADDR_W-1:0] are ignored (window is naturally aligned).
WAIT_CYCLES, 0, extra read wait cycles after data capture; legal range 0..15.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst  in  1  asynchronous, active-high reset.
cpu_addr  in  16  CPU address bus.
cpu_din  in  8  CPU write data.
cpu_dout  out  8  read data returned to the CPU.
cpu_doe  out  1  1 = bridge drives the CPU data bus.
cpu_mreq_n  in  1  memory request, active-low.
cpu_rd_n  in  1  read strobe, active-low.
cpu_wr_n  in  1  write strobe, active-low.
cpu_rfsh_n  in  1  refresh cycle, active-low.
cpu_wait_n  out  1  wait request to the CPU, active-low.
ram_ena  out  1  RAM enable.
ram_rd  out  1  RAM read strobe.
ram_wr  out  1  RAM write strobe.
ram_addr  out  ADDR_W  RAM address; equals cpu_addr[ADDR_W-1:0].
ram_din  out  8  RAM write data.
ram_dout  in  8  RAM registered read data.

Behaviour:
- All outputs are registered. Reset (asynchronous, any time, including mid-cycle) forces state IDLE, cpu_wait_n=1, cpu_doe=0, cpu_dout=0, ram_ena/rd/wr=0, ram_addr=0, ram_din=0, wait counter=0.
- hit = cpu_addr[15:ADDR_W] == BASE_ADDR[15:ADDR_W]. When ADDR_W=16, hit=1 always.
- Valid read (vr) = !mreq_n & !rd_n & wr_n & rfsh_n & hit.
- Valid write (vw) = !mreq_n & !wr_n & rd_n & rfsh_n & hit.
- rd_n and wr_n both low: neither vr nor vw. The bridge ignores the cycle and makes no RAM access.
- States: IDLE, RD_LAT, RD_CAP, RD_XW, WR_DONE, HOLD.
- IDLE, on vr: set ram_ena=1, ram_rd=1, ram_addr=cpu_addr[ADDR_W-1:0], cpu_wait_n=0. Go to RD_LAT.
- IDLE, on vw: set ram_ena=1, ram_wr=1, ram_addr, ram_din=cpu_din. Go to WR_DONE. Writes never assert wait.
- IDLE with a miss, refresh cycle or no strobe: stay in IDLE; outputs stay quiescent.
- RD_LAT (the RAM samples the request at this edge): set ram_ena=0, ram_rd=0. Go to RD_CAP.
- RD_CAP: cpu_dout <= ram_dout and cpu_doe <= 1.
  - If WAIT_CYCLES=0: cpu_wait_n <= 1, go to HOLD.
  - Otherwise: load counter with WAIT_CYCLES-1, go to RD_XW.
- RD_XW: decrement the counter each cycle. When counter=0, set cpu_wait_n=1 and go to HOLD.
- Read timing:
  - cpu_wait_n is low for exactly 2+WAIT_CYCLES cycles.
  - cpu_doe rises 2 cycles after the request edge.
  - Exactly one RAM read occurs per CPU read.
- WR_DONE: set ram_ena=0, ram_wr=0. Go to HOLD. Exactly one RAM write occurs per CPU write, whatever the strobe length.
- HOLD: stay in HOLD while mreq_n=0. When mreq_n=1, set cpu_doe=0 and go to IDLE (cpu_dout keeps its value). No new access starts until the bridge has returned to IDLE.
- Abort: if mreq_n goes high in RD_LAT, RD_CAP or RD_XW:
  - Clear ram_ena/rd, set cpu_wait_n=1, leave cpu_doe=0, go to IDLE.
  - cpu_dout is not updated.
- Address and data are captured only in IDLE. Changes to cpu_addr or cpu_din during later states have no effect.

Test Plan:
- Reset mid-read: assert rst while in RD_CAP -> all outputs at reset values the same cycle; no cpu_doe pulse after rst is released.
- Write with ADDR_W=14, BASE_ADDR=16'h4000: mreq_n=0, wr_n=0, cpu_addr=16'h4123, cpu_din=8'hA5, strobe held 4 cycles -> one cycle of ram_ena=ram_wr=1 with ram_addr=14'h0123 and ram_din=8'hA5; cpu_wait_n stays 1.
- Read back 16'h4123 with WAIT_CYCLES=0:
  - ram_rd pulses once; cpu_wait_n is low for 2 cycles.
  - cpu_dout=8'hA5 with cpu_doe=1 until mreq_n rises; cpu_doe=0 the next cycle.
- Read with WAIT_CYCLES=3 -> cpu_wait_n low for exactly 5 cycles; data valid with cpu_doe=1 from cycle 2.
- Miss and refresh:
  - Read 16'h8000 -> no RAM strobes, cpu_doe=0, cpu_wait_n=1.
  - Access to 16'h4000 with rfsh_n=0 -> no RAM strobes.
  - rd_n and wr_n both low -> no RAM strobes.
- Abort: mreq_n rises during RD_LAT -> cpu_wait_n=1 the next cycle, cpu_doe never asserts, state IDLE; an immediate following write to 16'h4001 completes normally.

Source files
------------

// File: rtl/z80_ram_bridge.sv
// z80_ram_bridge
// Converts Z80 memory cycles that fall inside an aligned address window into
// single accesses on a synchronous single-port RAM with a one-cycle registered
// read. CPU reads are stretched with cpu_wait_n_o until the RAM data has been
// captured, plus an optional number of extra wait cycles.
//
// Ports:
//   clk           system clock, everything on the rising edge
//   rst           asynchronous active-high reset
//   cpu_addr_i    CPU address bus
//   cpu_din_i     CPU write data
//   cpu_dout_o    read data returned to the CPU
//   cpu_doe_o     1 while the bridge drives the CPU data bus
//   cpu_mreq_n_i  memory request, active-low
//   cpu_rd_n_i    read strobe, active-low
//   cpu_wr_n_i    write strobe, active-low
//   cpu_rfsh_n_i  refresh cycle, active-low
//   cpu_wait_n_o  wait request to the CPU, active-low
//   ram_ena_o     RAM enable
//   ram_rd_o      RAM read strobe
//   ram_wr_o      RAM write strobe
//   ram_addr_o    RAM address (low ADDR_W bits of the CPU address)
//   ram_din_o     RAM write data
//   ram_dout_i    RAM registered read data

module z80_ram_bridge #(
  parameter int          ADDR_W      = 14,
  parameter logic [15:0] BASE_ADDR   = 16'h4000,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       cpu_addr_i,
  input  logic [7:0]        cpu_din_i,
  output logic [7:0]        cpu_dout_o,
  output logic              cpu_doe_o,
  input  logic              cpu_mreq_n_i,
  input  logic              cpu_rd_n_i,
  input  logic              cpu_wr_n_i,
  input  logic              cpu_rfsh_n_i,
  output logic              cpu_wait_n_o,
  output logic              ram_ena_o,
  output logic              ram_rd_o,
  output logic              ram_wr_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [7:0]        ram_din_o,
  input  logic [7:0]        ram_dout_i
);

  typedef enum logic [2:0] {
    IDLE,
    RD_LAT,
    RD_CAP,
    RD_XW,
    WR_DONE,
    HOLD
  } state_t;

  // Shifting by ADDR_W drops the in-window offset; with ADDR_W=16 both sides
  // become zero so every address hits.
  localparam logic [15:0] BASE_HI = BASE_ADDR >> ADDR_W;

  // Counter preload for the extra wait phase; only used when WAIT_CYCLES > 0.
  localparam logic [3:0] XW_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t              state_q;
  logic [3:0]          wcnt_q;
  logic [7:0]          dout_q;
  logic                doe_q;
  logic                wait_n_q;
  logic                ena_q;
  logic                rd_q;
  logic                wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          din_q;

  logic hit;
  logic valid_rd;
  logic valid_wr;

  assign hit      = (cpu_addr_i >> ADDR_W) == BASE_HI;
  assign valid_rd = !cpu_mreq_n_i && !cpu_rd_n_i &&  cpu_wr_n_i && cpu_rfsh_n_i && hit;
  assign valid_wr = !cpu_mreq_n_i && !cpu_wr_n_i &&  cpu_rd_n_i && cpu_rfsh_n_i && hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      wcnt_q   <= 4'd0;
      dout_q   <= 8'd0;
      doe_q    <= 1'b0;
      wait_n_q <= 1'b1;
      ena_q    <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      din_q    <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_rd) begin
            ena_q    <= 1'b1;
            rd_q     <= 1'b1;
            addr_q   <= cpu_addr_i[ADDR_W-1:0];
            wait_n_q <= 1'b0;
            state_q  <= RD_LAT;
          end else if (valid_wr) begin
            ena_q   <= 1'b1;
            wr_q    <= 1'b1;
            addr_q  <= cpu_addr_i[ADDR_W-1:0];
            din_q   <= cpu_din_i;
            state_q <= WR_DONE;
          end
        end

        // The RAM samples the read request on this edge, so the strobe is
        // dropped regardless of whether the CPU has abandoned the cycle.
        RD_LAT: begin
          ena_q <= 1'b0;
          rd_q  <= 1'b0;
          if (cpu_mreq_n_i) begin
            wait_n_q <= 1'b1;
            state_q  <= IDLE;
          end else begin
            state_q <= RD_CAP;
          end
        end

        RD_CAP: begin
          if (cpu_mreq_n_i) begin
            wait_n_q <= 1'b1;
            state_q  <= IDLE;
          end else begin
            dout_q <= ram_dout_i;
            doe_q  <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              wait_n_q <= 1'b1;
              state_q  <= HOLD;
            end else begin
              wcnt_q  <= XW_LOAD;
              state_q <= RD_XW;
            end
          end
        end

        // An abort here also releases the data bus, since the CPU has already
        // finished the cycle.
        RD_XW: begin
          if (cpu_mreq_n_i) begin
            wait_n_q <= 1'b1;
            doe_q    <= 1'b0;
            wcnt_q   <= 4'd0;
            state_q  <= IDLE;
          end else if (wcnt_q == 4'd0) begin
            wait_n_q <= 1'b1;
            state_q  <= HOLD;
          end else begin
            wcnt_q <= wcnt_q - 4'd1;
          end
        end

        WR_DONE: begin
          ena_q   <= 1'b0;
          wr_q    <= 1'b0;
          state_q <= HOLD;
        end

        // Parks until the CPU ends the cycle, so a long strobe never
        // produces a second RAM access.
        HOLD: begin
          if (cpu_mreq_n_i) begin
            doe_q   <= 1'b0;
            state_q <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cpu_dout_o   = dout_q;
  assign cpu_doe_o    = doe_q;
  assign cpu_wait_n_o = wait_n_q;
  assign ram_ena_o    = ena_q;
  assign ram_rd_o     = rd_q;
  assign ram_wr_o     = wr_q;
  assign ram_addr_o   = addr_q;
  assign ram_din_o    = din_q;

endmodule
